// File: rtl/alu_result_stage.sv
// Purpose : registered result stage behind the 64-bit ALU; buffers beats, owns NZCV flags, resolves branches.
// Latency : a beat accepted in cycle t is on out_* in cycle t+1 when the buffer was empty; flags update at t+1.
// Backpressure: in_ready drops when both entries are full; in_ready comes from registered count only, never from out_ready.
//
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   in_valid/in_ready       - ALU beat handshake; in_result, in_status {V,C,N,Z}, in_dest, in_wr_en,
//                             in_set_flags, in_is_branch, in_cond ride with it
//   out_valid/out_ready     - head-of-buffer handshake; out_result, out_dest, out_wr_en, out_branch_taken
//   flags                   - architectural {V,C,N,Z}
// Build option: define ALU_RESULT_XZR_EN to suppress register writes to dest 31 (zero register).

// Small generic FIFO with reset-cleared storage.
// Latency: pushed data is visible at pop_dat the cycle after push when empty.
// Backpressure: push_rdy is low only when full and depends on registered count alone.
module alu_result_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_vld,
    output logic         push_rdy,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push;
    logic             pop;

    assign push_rdy = (cnt_q != CNT_W'(DEPTH));
    assign pop_vld  = (cnt_q != '0);
    assign pop_dat  = mem_q[rd_ptr_q];
    assign push     = push_vld && push_rdy;
    // pop_vld gates the pop, so a push into an empty FIFO is never paired with a pop.
    assign pop      = pop_rdy && pop_vld;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

module alu_result_stage #(
    parameter int DEPTH = 2    // only 2 is supported
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_result,
    input  logic [3:0]  in_status,
    input  logic [4:0]  in_dest,
    input  logic        in_wr_en,
    input  logic        in_set_flags,
    input  logic        in_is_branch,
    input  logic [3:0]  in_cond,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_result,
    output logic [4:0]  out_dest,
    output logic        out_wr_en,
    output logic        out_branch_taken,
    output logic [3:0]  flags
);
    typedef struct packed {
        logic [63:0] result;
        logic [4:0]  dest;
        logic        wr_en;
        logic        taken;
    } entry_t;

    entry_t     push_entry;
    entry_t     head_entry;
    logic       accept;
    logic       cond_true;
    logic       wr_en_store;
    logic [3:0] flags_q, flags_d;
    logic       flag_v, flag_c, flag_n, flag_z;

    assign accept = in_valid && in_ready;
    assign {flag_v, flag_c, flag_n, flag_z} = flags_q;

    // Branches see the flags as they stood before this beat's own update.
    always_comb begin
        cond_true = 1'b1;
        case (in_cond)
            4'h0:    cond_true = flag_z;
            4'h1:    cond_true = !flag_z;
            4'h2:    cond_true = flag_c;
            4'h3:    cond_true = !flag_c;
            4'h4:    cond_true = flag_n;
            4'h5:    cond_true = !flag_n;
            4'h6:    cond_true = flag_v;
            4'h7:    cond_true = !flag_v;
            4'h8:    cond_true = flag_c && !flag_z;
            4'h9:    cond_true = !(flag_c && !flag_z);
            4'hA:    cond_true = (flag_n == flag_v);
            4'hB:    cond_true = (flag_n != flag_v);
            4'hC:    cond_true = !flag_z && (flag_n == flag_v);
            4'hD:    cond_true = !(!flag_z && (flag_n == flag_v));
            default: cond_true = 1'b1;
        endcase
    end

`ifdef ALU_RESULT_XZR_EN
    // Register 31 is the zero register: writes to it are dropped here.
    assign wr_en_store = in_wr_en && (in_dest != 5'd31);
`else
    assign wr_en_store = in_wr_en;
`endif

    always_comb begin
        push_entry.result = in_result;
        push_entry.dest   = in_dest;
        push_entry.wr_en  = wr_en_store;
        push_entry.taken  = in_is_branch && cond_true;
    end

    always_comb begin
        flags_d = flags_q;
        if (accept && in_set_flags) begin
            flags_d = in_status;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    alu_result_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (in_valid),
        .push_rdy (in_ready),
        .push_dat (push_entry),
        .pop_vld  (out_valid),
        .pop_rdy  (out_ready),
        .pop_dat  (head_entry)
    );

    assign out_result       = head_entry.result;
    assign out_dest         = head_entry.dest;
    assign out_wr_en        = head_entry.wr_en;
    assign out_branch_taken = head_entry.taken;
    assign flags            = flags_q;
endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_result;
    logic [3:0]  in_status;
    logic [4:0]  in_dest;
    logic        in_wr_en;
    logic        in_set_flags;
    logic        in_is_branch;
    logic [3:0]  in_cond;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_dest;
    logic        out_wr_en;
    logic        out_branch_taken;
    logic [3:0]  flags;

    int errors = 0;
    int checks = 0;

`ifdef ALU_RESULT_XZR_EN
    localparam bit XZR = 1'b1;
`else
    localparam bit XZR = 1'b0;
`endif

    alu_result_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_result        (in_result),
        .in_status        (in_status),
        .in_dest          (in_dest),
        .in_wr_en         (in_wr_en),
        .in_set_flags     (in_set_flags),
        .in_is_branch     (in_is_branch),
        .in_cond          (in_cond),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_result       (out_result),
        .out_dest         (out_dest),
        .out_wr_en        (out_wr_en),
        .out_branch_taken (out_branch_taken),
        .flags            (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [63:0] res;
        logic [3:0]  st;
        logic [4:0]  dst;
        logic        wr;
        logic        sf;
        logic        br;
        logic [3:0]  cnd;
        logic        ordy;
        logic        e_ov;
        logic        e_ir;
        logic        chk_head;
        logic [63:0] e_res;
        logic [4:0]  e_dst;
        logic        e_wr;
        logic        e_tk;
        logic [3:0]  e_fl;
    } vec_t;

    typedef struct {
        logic [63:0] r;
        logic [4:0]  d;
        logic        w;
        logic        t;
    } ment_t;

    vec_t  vecs[$];
    ment_t mq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_result = '0; in_status = '0; in_dest = '0; in_wr_en = 0;
        in_set_flags = 0; in_is_branch = 0; in_cond = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        out_ready = 0;
        #2 rst_n = 0;
        #7 rst_n = 1;
        step();
    endtask

    // Architectural condition rule: even codes test a base predicate, odd codes invert it, 14/15 always true.
    function automatic bit cond_ok(input logic [3:0] f, input logic [3:0] c);
        bit v, cf, n, z, base;
        v = f[3]; cf = f[2]; n = f[1]; z = f[0];
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cf;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cf && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c[3:1] == 3'd7) return 1'b1;
        return base ^ c[0];
    endfunction

    function automatic vec_t mk(input logic vld, input logic [63:0] res, input logic [3:0] st,
                                input logic [4:0] dst, input logic wr, input logic sf, input logic br,
                                input logic [3:0] cnd, input logic ordy, input logic e_ov, input logic e_ir,
                                input logic chk_head, input logic [63:0] e_res, input logic [4:0] e_dst,
                                input logic e_wr, input logic e_tk, input logic [3:0] e_fl);
        vec_t v;
        v.vld = vld; v.res = res; v.st = st; v.dst = dst; v.wr = wr; v.sf = sf; v.br = br;
        v.cnd = cnd; v.ordy = ordy; v.e_ov = e_ov; v.e_ir = e_ir; v.chk_head = chk_head;
        v.e_res = e_res; v.e_dst = e_dst; v.e_wr = e_wr; v.e_tk = e_tk; v.e_fl = e_fl;
        return v;
    endfunction

    initial begin
        //           vld res            st     dst wr sf br cnd  ordy ov ir hd res            dst wr tk fl
        vecs.push_back(mk(1, 64'hDEADBEEF, 4'h0, 3, 1, 0, 0, 4'h0, 1, 1, 1, 1, 64'hDEADBEEF, 3, 1, 0, 4'h0));
        vecs.push_back(mk(0, 64'h0,        4'h0, 0, 0, 0, 0, 4'h0, 1, 0, 1, 1, 64'h0,        0, 0, 0, 4'h0));
        vecs.push_back(mk(1, 64'h1,        4'h0, 1, 1, 0, 0, 4'h0, 0, 1, 1, 1, 64'h1,        1, 1, 0, 4'h0));
        vecs.push_back(mk(1, 64'h2,        4'h0, 2, 1, 0, 0, 4'h0, 0, 1, 0, 1, 64'h1,        1, 1, 0, 4'h0));
        vecs.push_back(mk(1, 64'h3,        4'h0, 3, 1, 0, 0, 4'h0, 0, 1, 0, 1, 64'h1,        1, 1, 0, 4'h0));
        vecs.push_back(mk(0, 64'h0,        4'h0, 0, 0, 0, 0, 4'h0, 1, 1, 1, 1, 64'h2,        2, 1, 0, 4'h0));
        vecs.push_back(mk(0, 64'h0,        4'h0, 0, 0, 0, 0, 4'h0, 1, 0, 1, 0, 64'h0,        0, 0, 0, 4'h0));
        vecs.push_back(mk(1, 64'h10,       4'h1, 4, 1, 1, 0, 4'h0, 1, 1, 1, 1, 64'h10,       4, 1, 0, 4'h1));
        vecs.push_back(mk(1, 64'h11,       4'h0, 5, 0, 0, 1, 4'h0, 1, 1, 1, 1, 64'h11,       5, 0, 1, 4'h1));
        vecs.push_back(mk(1, 64'h12,       4'h0, 6, 0, 0, 1, 4'h1, 1, 1, 1, 1, 64'h12,       6, 0, 0, 4'h1));
        vecs.push_back(mk(1, 64'h13,       4'h0, 7, 1, 1, 0, 4'h0, 1, 1, 1, 1, 64'h13,       7, 1, 0, 4'h0));
        vecs.push_back(mk(1, 64'h14,       4'h1, 8, 0, 1, 1, 4'h0, 1, 1, 1, 1, 64'h14,       8, 0, 0, 4'h1));
        vecs.push_back(mk(0, 64'h0,        4'h0, 0, 0, 0, 0, 4'h0, 1, 0, 1, 0, 64'h0,        0, 0, 0, 4'h1));
        vecs.push_back(mk(1, 64'h20,       4'h8, 9, 1, 1, 0, 4'h0, 0, 1, 1, 1, 64'h20,       9, 1, 0, 4'h8));
        vecs.push_back(mk(1, 64'h21,       4'h4, 10, 1, 1, 0, 4'h0, 0, 1, 0, 1, 64'h20,      9, 1, 0, 4'h4));
        vecs.push_back(mk(1, 64'h22,       4'h2, 11, 1, 1, 0, 4'h0, 0, 1, 0, 1, 64'h20,      9, 1, 0, 4'h4));
        vecs.push_back(mk(0, 64'h0,        4'h0, 0, 0, 0, 0, 4'h0, 1, 1, 1, 1, 64'h21,      10, 1, 0, 4'h4));
        vecs.push_back(mk(0, 64'h0,        4'h0, 0, 0, 0, 0, 4'h0, 1, 0, 1, 0, 64'h0,        0, 0, 0, 4'h4));
        vecs.push_back(mk(1, 64'h1F,       4'h0, 31, 1, 0, 0, 4'h0, 1, 1, 1, 1, 64'h1F,     31, !XZR, 0, 4'h4));
        vecs.push_back(mk(1, 64'h1E,       4'h0, 30, 1, 0, 1, 4'hE, 1, 1, 1, 1, 64'h1E,     30, 1, 1, 4'h4));
        vecs.push_back(mk(0, 64'h0,        4'h0, 0, 0, 0, 0, 4'h0, 1, 0, 1, 0, 64'h0,        0, 0, 0, 4'h4));

        rst_n = 1;
        idle_inputs();
        out_ready = 0;
        #2 rst_n = 0;
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_flags", flags, 0);
        check("reset_out_result", out_result, 0);
        check("reset_out_dest", out_dest, 0);
        check("reset_out_wr_en", out_wr_en, 0);
        check("reset_out_taken", out_branch_taken, 0);
        #6 rst_n = 1;
        step();

        // Table-driven directed vectors.
        foreach (vecs[i]) begin
            in_valid = vecs[i].vld; in_result = vecs[i].res; in_status = vecs[i].st;
            in_dest = vecs[i].dst; in_wr_en = vecs[i].wr; in_set_flags = vecs[i].sf;
            in_is_branch = vecs[i].br; in_cond = vecs[i].cnd; out_ready = vecs[i].ordy;
            step();
            check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_ov);
            check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_ir);
            check($sformatf("vec%0d_flags", i), flags, vecs[i].e_fl);
            if (vecs[i].chk_head) begin
                check($sformatf("vec%0d_out_result", i), out_result, vecs[i].e_res);
                check($sformatf("vec%0d_out_dest", i), out_dest, vecs[i].e_dst);
                check($sformatf("vec%0d_out_wr_en", i), out_wr_en, vecs[i].e_wr);
                check($sformatf("vec%0d_out_taken", i), out_branch_taken, vecs[i].e_tk);
            end
        end

        // Asynchronous reset with two beats buffered and flags = 1010.
        idle_inputs();
        out_ready = 0;
        in_valid = 1; in_result = 64'hA1; in_dest = 5'd1; in_wr_en = 1;
        step();
        in_result = 64'hA2; in_dest = 5'd2; in_set_flags = 1; in_status = 4'b1010;
        step();
        idle_inputs();
        check("midrst_pre_out_valid", out_valid, 1);
        check("midrst_pre_in_ready", in_ready, 0);
        check("midrst_pre_flags", flags, 4'b1010);
        #2 rst_n = 0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_flags", flags, 0);
        check("midrst_out_result", out_result, 0);
        check("midrst_out_dest", out_dest, 0);
        check("midrst_out_wr_en", out_wr_en, 0);
        #1 rst_n = 1;
        step();
        check("postrst_out_valid", out_valid, 0);
        check("postrst_flags", flags, 0);

        // Randomized traffic against a queue-based reference model.
        do_reset();
        begin
            logic [3:0] mflags;
            bit do_pop, do_push;
            ment_t e;
            mflags = '0;
            mq.delete();
            for (int i = 0; i < 500; i++) begin
                check("rnd_out_valid", out_valid, mq.size() != 0);
                check("rnd_in_ready", in_ready, mq.size() < 2);
                check("rnd_flags", flags, mflags);
                if (mq.size() != 0) begin
                    check("rnd_out_result", out_result, mq[0].r);
                    check("rnd_out_dest", out_dest, mq[0].d);
                    check("rnd_out_wr_en", out_wr_en, mq[0].w);
                    check("rnd_out_taken", out_branch_taken, mq[0].t);
                end
                in_valid     = ($urandom_range(0, 3) != 0);
                in_result    = {$urandom, $urandom};
                in_status    = 4'($urandom_range(0, 15));
                in_dest      = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
                in_wr_en     = $urandom_range(0, 1) != 0;
                in_set_flags = $urandom_range(0, 1) != 0;
                in_is_branch = $urandom_range(0, 1) != 0;
                in_cond      = 4'($urandom_range(0, 15));
                out_ready    = ($urandom_range(0, 2) != 0);

                do_pop  = out_ready && (mq.size() != 0);
                do_push = in_valid && (mq.size() < 2);
                e.r = in_result;
                e.d = in_dest;
                e.w = in_wr_en && !(XZR && in_dest == 5'd31);
                e.t = in_is_branch && cond_ok(mflags, in_cond);
                if (do_pop) void'(mq.pop_front());
                if (do_push) mq.push_back(e);
                if (do_push && in_set_flags) mflags = in_status;
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
